// File: rtl/stack_cpu_pkg.sv
// Shared types for the stack CPU: opcodes, sequencer states and error codes.
package stack_cpu_pkg;

  typedef enum logic [15:0] {
    OP_NOP  = 16'h0000,
    OP_IMM  = 16'h0002,
    OP_DUP  = 16'h0003,
    OP_DROP = 16'h0004,
    OP_HALT = 16'h00FF,
    OP_JMP  = 16'h1000,
    OP_JZ   = 16'h1001,
    OP_ADD  = 16'h2000,
    OP_SUB  = 16'h2001,
    OP_AND  = 16'h2002,
    OP_OR   = 16'h2003,
    OP_XOR  = 16'h2004
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPER, S_RD_A, S_RD_B, S_WRITE, S_HALT, S_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;
  localparam logic [1:0] ERR_ILL  = 2'd3;

endpackage

// File: rtl/stack_cpu_core_if.sv
// ROM fetch port and stack RAM port of the stack CPU.
interface stack_cpu_core_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  // No valid/ready here: memories return read data a fixed latency after the
  // address changes, and ram_wren is a one-cycle strobe qualifying ram_addr/ram_data.
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_data;

  modport master (output rom_addr, ram_addr, ram_wren, ram_data,
                  input  rom_q, ram_q);
  modport slave  (input  rom_addr, ram_addr, ram_wren, ram_data,
                  output rom_q, ram_q);
endinterface

// File: rtl/stack_cpu_alu.sv
// Combinational ALU for the binary stack ops; a is TOS, b is NOS.
module stack_cpu_alu
  import stack_cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  opcode_t           opcode,
  output logic [DATA_W-1:0] y
);
  always_comb begin
    y = '0;
    case (opcode)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/stack_cpu_core.sv
// Stack-machine sequencer: fetches from ROM, keeps the operand stack in RAM,
// flags over/underflow and illegal opcodes into a sticky error state.
module stack_cpu_core
  import stack_cpu_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int STACK_BASE  = 0,
  parameter int STACK_DEPTH = 256,
  parameter int ROM_LAT     = 2,
  parameter int RAM_LAT     = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  stack_cpu_core_if.master  mem,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] sp_out,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              halted,
  output logic              error,
  output logic [1:0]        err_code,
  output state_t            dbg_state
);
  localparam int CNT_W = $clog2((ROM_LAT > RAM_LAT ? ROM_LAT : RAM_LAT) + 1);
  localparam logic [CNT_W-1:0]  ROM_LAST = CNT_W'(ROM_LAT - 1);
  localparam logic [CNT_W-1:0]  RAM_LAST = CNT_W'(RAM_LAT - 1);
  localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W + 1)'(STACK_DEPTH);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(STACK_BASE);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, sp, sp_n, opnd, opnd_n, ram_addr_q, ram_addr_n;
  logic [DATA_W-1:0] ir, ir_n, a, a_n, ram_data_q, ram_data_n, result_q, result_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              wren_q, wren_n, rv_q, rv_n, halted_q, halted_n, error_q, error_n;
  logic [1:0]        err_q, err_n, fault;
  logic [DATA_W-1:0] alu_y;
  logic [15:0]       op;
  logic [ADDR_W-1:0] tos_addr, nos_addr, push_addr;
  logic              upper_bad, rom_done, ram_done, sp_empty, sp_full, sp_lt2;

  assign op        = ir[15:0];
  assign upper_bad = (ir >> 16) != '0;
  assign tos_addr  = BASE + sp - ONE;
  assign nos_addr  = BASE + sp - TWO;
  assign push_addr = BASE + sp;
  assign rom_done  = (cnt == ROM_LAST);
  assign ram_done  = (cnt == RAM_LAST);
  assign sp_empty  = (sp == '0);
  assign sp_full   = ({1'b0, sp} >= DEPTH);
  assign sp_lt2    = (sp < TWO);

  // NOS goes straight from ram_q into the ALU so the sum is ready as WRITE begins.
  stack_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a(a), .b(mem.ram_q), .opcode(opcode_t'(op)), .y(alu_y)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;   pc <= '0;       sp <= '0;        ir <= '0;
      opnd <= '0;         a <= '0;        cnt <= '0;       ram_addr_q <= '0;
      ram_data_q <= '0;   wren_q <= 1'b0; result_q <= '0;  rv_q <= 1'b0;
      halted_q <= 1'b0;   error_q <= 1'b0; err_q <= ERR_NONE;
    end else begin
      state <= state_n;   pc <= pc_n;     sp <= sp_n;      ir <= ir_n;
      opnd <= opnd_n;     a <= a_n;       cnt <= cnt_n;    ram_addr_q <= ram_addr_n;
      ram_data_q <= ram_data_n; wren_q <= wren_n; result_q <= result_n; rv_q <= rv_n;
      halted_q <= halted_n; error_q <= error_n; err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;  pc_n = pc;  sp_n = sp;  ir_n = ir;  opnd_n = opnd;  a_n = a;
    cnt_n = '0;  ram_addr_n = ram_addr_q;  ram_data_n = ram_data_q;  wren_n = 1'b0;
    result_n = result_q;  rv_n = 1'b0;  halted_n = halted_q;  error_n = error_q;
    err_n = err_q;  fault = ERR_NONE;
    case (state)
      S_FETCH:
        if (rom_done) begin ir_n = mem.rom_q; state_n = S_DECODE; end
        else cnt_n = cnt + 1'b1;
      S_DECODE: begin
        if (upper_bad) fault = ERR_ILL;
        else case (op)
          OP_NOP:  begin pc_n = pc + ONE; state_n = S_FETCH; end
          OP_JMP:  state_n = S_OPER;
          OP_JZ:   if (sp_empty) fault = ERR_UNF; else state_n = S_OPER;
          OP_IMM:  if (sp_full) fault = ERR_OVF; else state_n = S_OPER;
          OP_DUP:
            if (sp_empty) fault = ERR_UNF;
            else if (sp_full) fault = ERR_OVF;
            else begin ram_addr_n = tos_addr; state_n = S_RD_A; end
          OP_DROP:
            if (sp_empty) fault = ERR_UNF;
            else begin sp_n = sp - ONE; pc_n = pc + ONE; state_n = S_FETCH; end
          OP_HALT: begin halted_n = 1'b1; state_n = S_HALT; end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
            if (sp_lt2) fault = ERR_UNF;
            else begin ram_addr_n = tos_addr; state_n = S_RD_A; end
          default: fault = ERR_ILL;
        endcase
        if (fault != ERR_NONE) begin
          err_n = fault; error_n = 1'b1; state_n = S_ERROR;
        end
      end
      S_OPER:
        if (!rom_done) cnt_n = cnt + 1'b1;
        else case (op)
          OP_JMP: begin pc_n = ADDR_W'(mem.rom_q); state_n = S_FETCH; end
          OP_JZ:  begin opnd_n = ADDR_W'(mem.rom_q); ram_addr_n = tos_addr; state_n = S_RD_A; end
          default: begin
            ram_addr_n = push_addr; ram_data_n = mem.rom_q; wren_n = 1'b1;
            result_n = mem.rom_q; rv_n = 1'b1; state_n = S_WRITE;
          end
        endcase
      S_RD_A:
        if (!ram_done) cnt_n = cnt + 1'b1;
        else begin
          a_n = mem.ram_q;
          case (op)
            OP_JZ: begin
              sp_n = sp - ONE;
              pc_n = (mem.ram_q == '0) ? opnd : pc + TWO;
              state_n = S_FETCH;
            end
            OP_DUP: begin
              ram_addr_n = push_addr; ram_data_n = mem.ram_q; wren_n = 1'b1;
              result_n = mem.ram_q; rv_n = 1'b1; state_n = S_WRITE;
            end
            default: begin ram_addr_n = nos_addr; state_n = S_RD_B; end
          endcase
        end
      S_RD_B:
        if (!ram_done) cnt_n = cnt + 1'b1;
        else begin
          ram_data_n = alu_y; wren_n = 1'b1; result_n = alu_y; rv_n = 1'b1;
          state_n = S_WRITE;
        end
      S_WRITE: begin
        case (op)
          OP_IMM:  begin sp_n = sp + ONE; pc_n = pc + TWO; end
          OP_DUP:  begin sp_n = sp + ONE; pc_n = pc + ONE; end
          default: begin sp_n = sp - ONE; pc_n = pc + ONE; end
        endcase
        state_n = S_FETCH;
      end
      S_HALT, S_ERROR: state_n = state;
      default: state_n = S_FETCH;
    endcase
  end

  assign mem.rom_addr = (state == S_OPER) ? pc + ONE : pc;
  assign mem.ram_addr = ram_addr_q;
  assign mem.ram_data = ram_data_q;
  assign mem.ram_wren = wren_q;
  assign pc_out       = pc;
  assign sp_out       = sp;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign halted       = halted_q;
  assign error        = error_q;
  assign err_code     = err_q;
  assign dbg_state    = state;
endmodule

// File: doc/stack_cpu_core.md
Name: stack_cpu_core

Overview:
Parametrised successor to the team's 16-bit stack-machine ALU/sequencer. It fetches instructions from ROM, keeps the operand stack in RAM, and executes push, arithmetic/logic, stack-manipulation, branch and halt instructions.
- Memory read latencies, data width and stack geometry are parameters.
- Adds over/underflow detection, a conditional branch, HALT, and a sticky error state with a code.
- Sits between the ROM/RAM IP and the 7-segment/debug outputs.

Parameters:
DATA_W, 16, data/instruction word width (≥16; opcodes occupy bits [15:0], upper bits must be 0)
ADDR_W, 16, ROM and RAM address width
STACK_BASE, 0, RAM address of stack entry 0
STACK_DEPTH, 256, maximum number of stack entries
ROM_LAT, 2, cycles from rom_addr change to valid rom_q (≥1)
RAM_LAT, 1, cycles from ram_addr change to valid ram_q (≥1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
rom_addr  out  ADDR_W  instruction/operand fetch address (= pc)
rom_q  in  DATA_W  ROM read data
ram_addr  out  ADDR_W  stack RAM address
ram_q  in  DATA_W  RAM read data
ram_wren  out  1  RAM write enable, single-cycle pulse
ram_data  out  DATA_W  RAM write data
pc_out  out  ADDR_W  current pc (debug)
sp_out  out  ADDR_W  current stack entry count (debug)
result  out  DATA_W  last ALU/pushed value (7-seg)
result_valid  out  1  one-cycle pulse when result updates
halted  out  1  sticky, HALT executed
error  out  1  sticky, core in ERROR
err_code  out  2  0 none, 1 overflow, 2 underflow, 3 illegal opcode

Behaviour:
- Reset (async assert, sync release) clears: pc, sp, ir, state=FETCH, ram_addr, ram_data, result, err_code to 0; ram_wren, result_valid, halted, error to 0. ram_wren drops immediately on reset assertion.
- States: FETCH, DECODE, OPER, RD_A, RD_B, WRITE, HALT, ERROR. A shared wait counter counts latency cycles.
- FETCH: hold rom_addr=pc for ROM_LAT cycles, then latch rom_q into ir and go to DECODE.
- OPER: operand fetch from pc+1; ROM_LAT cycles.
- Push target address = STACK_BASE+sp. TOS is at STACK_BASE+sp-1; NOS is at STACK_BASE+sp-2.
- NOP 0x0000: pc+1. Total ROM_LAT+1 cycles.
- JMP 0x1000: OPER; pc=operand.
- JZ 0x1001: needs sp≥1. OPER, then RD_A reads TOS; sp-1; pc=operand if TOS==0, else pc+2.
- IMM 0x0002: needs sp<STACK_DEPTH. OPER; WRITE pushes operand; sp+1; pc+2.
- DUP 0x0003: needs 1≤sp<STACK_DEPTH. RD_A reads TOS; WRITE pushes it; sp+1; pc+1.
- DROP 0x0004: needs sp≥1. sp-1; pc+1; no RAM access.
- HALT 0x00FF: enter HALT. halted=1; pc, sp and outputs frozen until reset.
- Binary ops ADD 0x2000, SUB 0x2001, AND 0x2002, OR 0x2003, XOR 0x2004: need sp≥2.
  - RD_A reads TOS into a (RAM_LAT cycles); RD_B reads NOS into b.
  - WRITE puts (a op b) at STACK_BASE+sp-2; sp-1; pc+1.
  - SUB = TOS−NOS. Arithmetic wraps modulo 2^DATA_W; no carry/flag output.
- ram_wren is high exactly one cycle, in WRITE, with ram_addr/ram_data valid that same cycle.
- result/result_valid update in WRITE for IMM, DUP and binary ops.
- Checks happen in DECODE, before any RAM access or pc change:
  - overflow → err_code=1
  - underflow → err_code=2
  - unknown opcode, or nonzero upper bits when DATA_W>16 → err_code=3
- ERROR: error=1; nothing written; pc/sp hold the faulting values. Sticky until reset.
- pc wraps modulo 2^ADDR_W.
- Reset mid-instruction abandons the instruction; no partial write survives beyond the already-completed WRITE cycle.

Decomposition:
- Package stack_cpu_pkg: opcode enum, state enum, err_code localparams.
- Combinational sub-module stack_cpu_alu: inputs a, b, opcode; output DATA_W result.
- All sequencing stays in stack_cpu_core.

Test Plan:
Defaults apply unless stated; ROM/RAM models honour ROM_LAT/RAM_LAT.
1. ROM: IMM 5, IMM 3, SUB, HALT → RAM[0]=5 then RAM[1]=3; SUB writes 0xFFFE to RAM[0]; sp=1; result=0xFFFE; halted=1; pc frozen at 5.
2. NOP,NOP,HALT → pc reaches 2 after exactly 2×(ROM_LAT+1)=6 cycles from reset release; no ram_wren ever.
3. IMM 0, JZ 0x0010 and separately IMM 7, JZ 0x0010 → pc=0x0010 in the first case, pc=4 in the second; sp=0 in both.
4. STACK_DEPTH=4, five IMM 1 → four writes (RAM[0..3]); the fifth raises error=1, err_code=1, sp=4, no fifth ram_wren.
5. IMM 9, ADD → err_code=2, RAM[0] still 9; separately ROM word 0x1234 → err_code=3, pc=0.
6. Assert reset_n low during RD_B of an ADD → ram_wren=0 immediately, pc=sp=0, error=0; after release the program re-executes from 0 with the same final RAM contents.
